// File: rtl/ahb_param_arbiter_if.sv
// Purpose: bus-side signal bundle between the AHB arbiter and the muxed master/slave fabric.
// Latency: none (wires only).
// Backpressure: carries HREADY, which stalls both arbitration and address-phase handover.
//
// Signals:
//   HBUSREQ/HLOCK  per-master request and lock request
//   HTRANS/HREADY/HRESP  muxed transfer type, slave ready, response
//   HGRANT/HMASTER/HMASTLOCK  arbiter outputs: one-hot grant, address-phase owner, lock flag
// Modports: master = requesting side (drives requests, sees grant),
//           slave  = arbiter side (sees requests, drives grant).
interface ahb_param_arbiter_if #(
    parameter int N_MASTERS   = 4,
    parameter int MASTER_BITS = $clog2(N_MASTERS)
) ();
    logic [N_MASTERS-1:0]   HBUSREQ;
    logic [N_MASTERS-1:0]   HLOCK;
    logic [1:0]             HTRANS;
    logic                   HREADY;
    logic [1:0]             HRESP;
    logic [N_MASTERS-1:0]   HGRANT;
    logic [MASTER_BITS-1:0] HMASTER;
    logic                   HMASTLOCK;

    modport master (
        output HBUSREQ, HLOCK, HTRANS, HREADY, HRESP,
        input  HGRANT, HMASTER, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ, HLOCK, HTRANS, HREADY, HRESP,
        output HGRANT, HMASTER, HMASTLOCK
    );
endinterface

// File: rtl/ahb_param_arbiter.sv
// Purpose: N-master AHB arbiter, fixed-priority or round-robin, with lock hold and tenure limit.
// Latency: request to HGRANT 1 cycle; HGRANT to HMASTER/HMASTLOCK at the next HREADY=1 edge.
// Backpressure: HREADY=0 freezes grant, owner, lock flag and hold counter.
//
// Ports:
//   HCLK    bus clock
//   HRESET  synchronous active-high reset
//   bus     ahb_param_arbiter_if.slave: HBUSREQ/HLOCK/HTRANS/HREADY/HRESP in,
//           HGRANT/HMASTER/HMASTLOCK out (all outputs registered)
// HRESP is deliberately not consulted: RETRY and SPLIT get no special grant handling.
module ahb_param_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int MASTER_BITS    = $clog2(N_MASTERS),
    parameter int DEFAULT_MASTER = 0,
    parameter int ARB_MODE       = 1,
    parameter int MAX_HOLD       = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_param_arbiter_if.slave    bus
);

    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [MASTER_BITS-1:0] DEF_IDX = MASTER_BITS'(DEFAULT_MASTER);
    localparam logic [CNT_W-1:0]       CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [1:0]             HTRANS_IDLE = 2'b00;

    logic [N_MASTERS-1:0]   hgrant_q,    hgrant_d;
    logic [MASTER_BITS-1:0] hmaster_q,   hmaster_d;
    logic                   hmastlock_q, hmastlock_d;
    logic [CNT_W-1:0]       hold_cnt_q,  hold_cnt_d;
    logic [MASTER_BITS-1:0] rr_ptr_q,    rr_ptr_d;

    logic [MASTER_BITS-1:0] owner_idx;
    logic [MASTER_BITS-1:0] win_idx;
    logic                   win_found;
    logic                   any_req;
    logic                   others_req;
    logic                   lock_hold;
    logic                   hold_limit;
    logic                   arb_point;
    logic                   grant_change;

    // Grant is always one-hot, so the last set bit found is the only one.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (hgrant_q[i]) begin
                owner_idx = MASTER_BITS'(i);
            end
        end
    end

    always_comb begin
        any_req    = |bus.HBUSREQ;
        others_req = |(bus.HBUSREQ & ~hgrant_q);
        // The registered lock flag keeps the grant through the data phase of
        // the last locked beat, after the owner has already dropped HLOCK.
        lock_hold  = bus.HLOCK[owner_idx] | hmastlock_q;
        hold_limit = (MAX_HOLD != 0) && (hold_cnt_q >= CNT_MAX) && others_req;
        arb_point  = bus.HREADY && !lock_hold &&
                     ((bus.HTRANS == HTRANS_IDLE) || !bus.HBUSREQ[owner_idx] || hold_limit);
    end

    // Winner: lowest index in fixed mode, first requester after the pointer
    // (wrapping) in round-robin mode, default master when nobody requests.
    always_comb begin
        int cand;
        win_idx   = DEF_IDX;
        win_found = 1'b0;
        cand      = 0;
        if (ARB_MODE == 0) begin
            for (int i = N_MASTERS - 1; i >= 0; i--) begin
                if (bus.HBUSREQ[i]) begin
                    win_idx = MASTER_BITS'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N_MASTERS; k++) begin
                cand = (int'(rr_ptr_q) + k) % N_MASTERS;
                if (!win_found && bus.HBUSREQ[cand]) begin
                    win_idx   = MASTER_BITS'(cand);
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hgrant_d     = hgrant_q;
        hmaster_d    = hmaster_q;
        hmastlock_d  = hmastlock_q;
        hold_cnt_d   = hold_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        grant_change = arb_point && (win_idx != owner_idx);

        if (grant_change) begin
            hgrant_d          = '0;
            hgrant_d[win_idx] = 1'b1;
        end

        if (arb_point && any_req) begin
            rr_ptr_d = win_idx;
        end

        // A forced re-arbitration restarts the tenure even if the owner wins again.
        if (grant_change || (arb_point && hold_limit)) begin
            hold_cnt_d = '0;
        end else if (bus.HREADY && bus.HTRANS[1] && (hold_cnt_q < CNT_MAX)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end

        // Address-phase ownership follows the grant only on accepted cycles.
        if (bus.HREADY) begin
            hmaster_d   = owner_idx;
            hmastlock_d = bus.HLOCK[owner_idx];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            hgrant_q          <= '0;
            hgrant_q[DEF_IDX] <= 1'b1;
            hmaster_q         <= DEF_IDX;
            hmastlock_q       <= 1'b0;
            hold_cnt_q        <= '0;
            rr_ptr_q          <= DEF_IDX;
        end else begin
            hgrant_q    <= hgrant_d;
            hmaster_q   <= hmaster_d;
            hmastlock_q <= hmastlock_d;
            hold_cnt_q  <= hold_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.HGRANT    = hgrant_q;
    assign bus.HMASTER   = hmaster_q;
    assign bus.HMASTLOCK = hmastlock_q;

endmodule
